// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, the instruction memory and decode.
// master = fetch controller side, slave = memory/decode/control side.
interface imem_fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halt_ack;
    logic        fetch_fault;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst_pc,
        output inst_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output halt_ack,
        output fetch_fault
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst_pc,
        input  inst_data,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  halt_ack,
        input  fetch_fault
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: PC, prefetch FIFO, redirect flush and halt.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    imem_fetch_ctrl_if.master  bus
);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      LAST_PC  = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        RUN,
        HALT
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT
`endif
    } state_t;

    state_t             state, state_n;
    logic [31:0]        fetch_pc, fetch_pc_n;
    logic [31:0]        pc_inc, next_pc;
    logic [31:0]        target;
    logic               misaligned;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, count_n;
    logic               halt_ack_q, halt_ack_n;
    logic               push, pop, flush, full, inst_valid;
    logic [31:0]        pc_q   [FIFO_DEPTH];
    logic [31:0]        data_q [FIFO_DEPTH];

    assign pc_inc  = fetch_pc + 32'd4;
    assign next_pc = (pc_inc > LAST_PC) ? '0 : pc_inc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target          = bus.redirect_pc;
    assign misaligned      = |bus.redirect_pc[1:0];
    assign bus.fetch_fault = (state == FAULT);
`else
    logic [1:0] unused_pc_lsb;
    assign unused_pc_lsb   = bus.redirect_pc[1:0];
    assign target          = {bus.redirect_pc[31:2], 2'b00};
    assign misaligned      = 1'b0;
    assign bus.fetch_fault = 1'b0;
`endif

    assign full          = (count == FULL_CNT);
    assign inst_valid    = (count != '0);
    assign pop           = inst_valid & bus.inst_ready;
    assign bus.inst_valid = inst_valid;
    assign bus.inst_pc   = inst_valid ? pc_q[rd_ptr]   : '0;
    assign bus.inst_data = inst_valid ? data_q[rd_ptr] : '0;
    assign bus.imem_addr = fetch_pc;
    assign bus.halt_ack  = halt_ack_q;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        push       = 1'b0;
        flush      = 1'b0;
        if (bus.redirect_valid) begin
            flush      = 1'b1;
            fetch_pc_n = target;
            if (misaligned) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state_n = FAULT;
`endif
            end else if (state == HALT && bus.halt_req) begin
                state_n = HALT;
            end else begin
                state_n = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    // The cycle that raises halt_req is still a RUN cycle and may push.
                    if (bus.halt_req) state_n = HALT;
                    push = !full || pop;
                    if (push) fetch_pc_n = next_pc;
                end
                HALT: begin
                    if (!bus.halt_req) state_n = RUN;
                end
                default: state_n = state;
            endcase
        end

        if (flush) begin
            count_n = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_n = count + CNT_W'(1);
                2'b01:   count_n = count - CNT_W'(1);
                default: count_n = count;
            endcase
        end
        // Registered, but computed from next state so it tracks HALT & empty exactly.
        halt_ack_n = (state_n == HALT) && (count_n == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            halt_ack_q <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            count      <= count_n;
            halt_ack_q <= halt_ack_n;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= fetch_pc;
            data_q[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: cycle table plus reset/stream/wrap sequences.
module tb_imem_fetch_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int checks = 0;
    int errors = 0;

    imem_fetch_ctrl_if bus_a ();
    imem_fetch_ctrl_if bus_b ();

    imem_fetch_ctrl dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    imem_fetch_ctrl #(.IMEM_BYTES(16)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    function automatic logic [31:0] instr(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0640_0293;
            32'h4:   return 32'h0000_8113;
            32'h8:   return 32'h0011_0193;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign bus_a.imem_rdata = instr(bus_a.imem_addr);
    assign bus_b.imem_rdata = instr(bus_b.imem_addr);

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        halt;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        eack;
        logic        efault;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic halt,
                                input logic rdy, input logic ev, input logic [31:0] epc,
                                input logic [31:0] eaddr, input logic eack, input logic efault);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.halt = halt; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.eack = eack; v.efault = efault;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = '0;
        bus_a.halt_req       = 1'b0;
        bus_a.inst_ready     = 1'b0;
        next_cycle();
        next_cycle();
        rst_a = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = '0;
        bus_b.halt_req       = 1'b0;
        bus_b.inst_ready     = 1'b0;

        // Reset state, sampled while reset is still held.
        reset_a();
        rst_a = 1'b1;
        @(negedge clk);
        chk("rst_valid", 0, 32'(bus_a.inst_valid), 32'h0);
        chk("rst_pc",    0, bus_a.inst_pc,         32'h0);
        chk("rst_data",  0, bus_a.inst_data,       32'h0);
        chk("rst_addr",  0, bus_a.imem_addr,       32'h0);
        chk("rst_ack",   0, 32'(bus_a.halt_ack),   32'h0);
        chk("rst_fault", 0, 32'(bus_a.fetch_fault), 32'h0);

        // Streaming from reset with decode always ready.
        reset_a();
        bus_a.inst_ready = 1'b1;
        @(negedge clk);
        chk("s_c0_valid", 0, 32'(bus_a.inst_valid), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk("s_valid", c, 32'(bus_a.inst_valid), 32'h1);
            chk("s_pc",    c, bus_a.inst_pc,  32'((c - 1) * 4));
            chk("s_data",  c, bus_a.inst_data, instr(32'((c - 1) * 4)));
        end

        // Cycle table: backpressure, full-FIFO redirect, halt/drain/resume, misaligned redirect.
        tbl[0]  = mk(0, 32'h00, 0, 0, 0, 32'h00, 32'h00, 0, 0);
        tbl[1]  = mk(0, 32'h00, 0, 0, 1, 32'h00, 32'h04, 0, 0);
        tbl[2]  = mk(0, 32'h00, 0, 0, 1, 32'h00, 32'h08, 0, 0);
        tbl[3]  = mk(0, 32'h00, 0, 0, 1, 32'h00, 32'h08, 0, 0);
        tbl[4]  = mk(0, 32'h00, 0, 0, 1, 32'h00, 32'h08, 0, 0);
        tbl[5]  = mk(0, 32'h00, 0, 1, 1, 32'h00, 32'h08, 0, 0);
        tbl[6]  = mk(0, 32'h00, 0, 1, 1, 32'h04, 32'h0c, 0, 0);
        tbl[7]  = mk(0, 32'h00, 0, 0, 1, 32'h08, 32'h10, 0, 0);
        tbl[8]  = mk(1, 32'h14, 0, 0, 1, 32'h08, 32'h10, 0, 0);
        tbl[9]  = mk(0, 32'h00, 0, 1, 0, 32'h00, 32'h14, 0, 0);
        tbl[10] = mk(0, 32'h00, 0, 1, 1, 32'h14, 32'h18, 0, 0);
        tbl[11] = mk(0, 32'h00, 0, 0, 1, 32'h18, 32'h1c, 0, 0);
        tbl[12] = mk(0, 32'h00, 1, 1, 1, 32'h18, 32'h20, 0, 0);
        tbl[13] = mk(0, 32'h00, 1, 1, 1, 32'h1c, 32'h24, 0, 0);
        tbl[14] = mk(0, 32'h00, 1, 1, 1, 32'h20, 32'h24, 0, 0);
        tbl[15] = mk(0, 32'h00, 1, 1, 0, 32'h00, 32'h24, 1, 0);
        tbl[16] = mk(0, 32'h00, 0, 1, 0, 32'h00, 32'h24, 1, 0);
        tbl[17] = mk(0, 32'h00, 0, 1, 0, 32'h00, 32'h24, 0, 0);
        tbl[18] = mk(0, 32'h00, 0, 1, 1, 32'h24, 32'h28, 0, 0);
        tbl[19] = mk(1, 32'h22, 0, 1, 1, 32'h28, 32'h2c, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        tbl[20] = mk(0, 32'h00, 0, 1, 0, 32'h00, 32'h22, 0, 1);
        tbl[21] = mk(0, 32'h00, 0, 1, 0, 32'h00, 32'h22, 0, 1);
        tbl[22] = mk(1, 32'h24, 0, 1, 0, 32'h00, 32'h22, 0, 1);
`else
        tbl[20] = mk(0, 32'h00, 0, 1, 0, 32'h00, 32'h20, 0, 0);
        tbl[21] = mk(0, 32'h00, 0, 1, 1, 32'h20, 32'h24, 0, 0);
        tbl[22] = mk(1, 32'h24, 0, 1, 1, 32'h24, 32'h28, 0, 0);
`endif
        tbl[23] = mk(0, 32'h00, 0, 1, 0, 32'h00, 32'h24, 0, 0);
        tbl[24] = mk(0, 32'h00, 0, 1, 1, 32'h24, 32'h28, 0, 0);

        reset_a();
        for (int i = 0; i < 25; i++) begin
            bus_a.redirect_valid = tbl[i].rv;
            bus_a.redirect_pc    = tbl[i].rpc;
            bus_a.halt_req       = tbl[i].halt;
            bus_a.inst_ready     = tbl[i].rdy;
            @(negedge clk);
            chk("t_valid", i, 32'(bus_a.inst_valid), 32'(tbl[i].ev));
            chk("t_addr",  i, bus_a.imem_addr,       tbl[i].eaddr);
            chk("t_ack",   i, 32'(bus_a.halt_ack),   32'(tbl[i].eack));
            chk("t_fault", i, 32'(bus_a.fetch_fault), 32'(tbl[i].efault));
            if (tbl[i].ev) begin
                chk("t_pc",   i, bus_a.inst_pc,   tbl[i].epc);
                chk("t_data", i, bus_a.inst_data, instr(tbl[i].epc));
            end
            next_cycle();
        end
        bus_a.redirect_valid = 1'b0;

        // Small IMEM: sequential wrap, then reset asserted mid-stream.
        rst_b = 1'b1;
        next_cycle();
        next_cycle();
        rst_b = 1'b0;
        bus_b.inst_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            @(negedge clk);
            chk("w_valid", c, 32'(bus_b.inst_valid), 32'h1);
            chk("w_pc",    c, bus_b.inst_pc, (c == 5) ? 32'h0 : 32'((c - 1) * 4));
            if (c == 4) chk("w_addr", c, bus_b.imem_addr, 32'h0);
        end
        next_cycle();
        rst_b = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("mid_rst_valid", 0, 32'(bus_b.inst_valid), 32'h0);
        chk("mid_rst_addr",  0, bus_b.imem_addr,       32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
